// File: rtl/mult_booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth shift-add multiplier datapath.
// Steps LOAD, then N EVAL/SHIFT pairs, then DONE, and keeps a product-valid level.
module mult_booth_ctrl #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] Q_LSB,
    output logic       load_A,
    output logic       load_B,
    output logic       load_add,
    output logic       add_sub,
    output logic       shift_HQ_LQ,
    output logic       busy,
    output logic       done,
    output logic       y_valid
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             y_valid_q, y_valid_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_valid_d   = y_valid_q;
        load_A      = 1'b0;
        load_B      = 1'b0;
        load_add    = 1'b0;
        add_sub     = 1'b0;
        shift_HQ_LQ = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = S_LOAD;
                    y_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                load_A  = 1'b1;
                load_B  = 1'b1;
                cnt_d   = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                // Q_LSB comes straight from datapath flops updated only by LOAD/SHIFT.
                unique case (Q_LSB)
                    2'b01: begin
                        load_add = 1'b1;
                        add_sub  = 1'b0;
                    end
                    2'b10: begin
                        load_add = 1'b1;
                        add_sub  = 1'b1;
                    end
                    default: begin
                        load_add = 1'b0;
                        add_sub  = 1'b0;
                    end
                endcase
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift_HQ_LQ = 1'b1;
                cnt_d       = cnt_inc;
                state_d     = (cnt_inc < CNT_W'(N)) ? S_EVAL : S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                y_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Scoreboard bench for mult_booth_ctrl: a behavioural Booth datapath closes the loop,
// or Q_LSB is forced to a constant to exercise the controller alone.
module tb_mult_booth_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] Q_LSB;
    logic load_A, load_B, load_add, add_sub, shift_HQ_LQ, busy, done, y_valid;

    always #5 clk = ~clk;

    mult_booth_ctrl #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Q_LSB      (Q_LSB),
        .load_A     (load_A),
        .load_B     (load_B),
        .load_add   (load_add),
        .add_sub    (add_sub),
        .shift_HQ_LQ(shift_HQ_LQ),
        .busy       (busy),
        .done       (done),
        .y_valid    (y_valid)
    );

    // Behavioural datapath with a 9-bit accumulator so -128 operands do not overflow.
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [7:0] a_reg = '0;
    logic [8:0] acc = '0;
    logic [7:0] q_reg = '0;
    logic       q_m1 = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'b00;
    logic [15:0] y_out;

    always @(posedge clk) begin
        if (load_A) a_reg <= a_in;
        if (load_B) begin
            q_reg <= b_in;
            acc   <= '0;
            q_m1  <= 1'b0;
        end else if (load_add) begin
            acc <= add_sub ? acc - {a_reg[7], a_reg} : acc + {a_reg[7], a_reg};
        end else if (shift_HQ_LQ) begin
            {acc, q_reg, q_m1} <= {acc[8], acc, q_reg};
        end
    end

    assign Q_LSB = force_en ? force_val : {q_reg[0], q_m1};
    assign y_out = {acc[7:0], q_reg};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    typedef struct {
        int          done_cyc;
        logic        chk_y;
        logic [15:0] y;
        int          adds;
        int          subs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic pend = 1'b0;
    int   n_add, n_sub, n_shift, n_ovl, n_bad;

    // Monitor: tallies strobes per operation and pops the scoreboard on each done.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            n_add = 0; n_sub = 0; n_shift = 0; n_ovl = 0; n_bad = 0;
        end else begin
            if (pend) begin
                check("y_valid_after_done", int'(y_valid), 1);
                if (cur.chk_y) check("product", int'(y_out), int'(cur.y));
                pend = 1'b0;
            end
            if (load_B) begin
                n_add = 0; n_sub = 0; n_shift = 0; n_ovl = 0; n_bad = 0;
            end
            if (int'(load_B) + int'(load_add) + int'(shift_HQ_LQ) > 1) n_ovl++;
            if (!load_add && add_sub) n_bad++;
            if (load_add) n_add++;
            if (load_add && add_sub) n_sub++;
            if (shift_HQ_LQ) n_shift++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check("done_cycle", cyc, cur.done_cyc);
                    check("shift_count", n_shift, 8);
                    check("strobe_overlap", n_ovl, 0);
                    check("add_sub_idle", n_bad, 0);
                    check("busy_in_done", int'(busy), 1);
                    check("y_valid_in_done", int'(y_valid), 0);
                    if (cur.adds >= 0) check("load_add_count", n_add, cur.adds);
                    if (cur.subs >= 0) check("subtract_count", n_sub, cur.subs);
                    pend = 1'b1;
                end
            end
        end
    end

    // Raises start at a negedge; the following posedge samples it (LOAD at s+1, DONE at s+18).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic fen,
                         input logic [1:0] fval, input logic chk_y, input logic [15:0] y,
                         input int adds, input int subs, output int s);
        exp_t e;
        a_in = a; b_in = b; force_en = fen; force_val = fval;
        start = 1'b1;
        s = cyc;
        e.done_cyc = s + 18; e.chk_y = chk_y; e.y = y; e.adds = adds; e.subs = subs;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !pend) break;
            @(negedge clk);
        end
        if (sb.size() != 0 || pend) begin
            check("op_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int s;

    initial begin
        // Reset held with start high: every output must stay low.
        start = 1'b1;
        a_in = 8'd3; b_in = 8'd5;
        repeat (2) @(negedge clk);
        check("rst_load_A", int'(load_A), 0);
        check("rst_load_B", int'(load_B), 0);
        check("rst_load_add", int'(load_add), 0);
        check("rst_add_sub", int'(add_sub), 0);
        check("rst_shift", int'(shift_HQ_LQ), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_y_valid", int'(y_valid), 0);

        rst = 1'b0;
        issue(8'd3, 8'd5, 1'b0, 2'b00, 1'b1, 16'd15, 4, 2, s);
        check("load_A_at_s1", int'(load_A), 1);
        check("load_B_at_s1", int'(load_B), 1);
        check("busy_at_s1", int'(busy), 1);
        wait_empty();
        check("y_valid_held", int'(y_valid), 1);

        @(negedge clk);
        issue(8'hF9, 8'd6, 1'b0, 2'b00, 1'b1, 16'hFFD6, -1, -1, s);
        check("y_valid_cleared_on_load", int'(y_valid), 0);
        wait_empty();

        @(negedge clk);
        issue(8'h80, 8'h80, 1'b0, 2'b00, 1'b1, 16'h4000, 1, 1, s);
        wait_empty();

        @(negedge clk);
        issue(8'd9, 8'd9, 1'b1, 2'b10, 1'b0, 16'h0, 8, 8, s);
        wait_empty();

        @(negedge clk);
        issue(8'd9, 8'd9, 1'b1, 2'b11, 1'b0, 16'h0, 0, 0, s);
        wait_empty();

        // Start pulse during SHIFT of iteration 3 must be ignored.
        @(negedge clk);
        issue(8'd12, 8'hFD, 1'b0, 2'b00, 1'b1, 16'hFFDC, -1, -1, s);
        wait_until(s + 9);
        check("shift_iter3", int'(shift_HQ_LQ), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        check("no_queued_start_busy", int'(busy), 0);

        // Reset during EVAL of iteration 5 aborts the operation.
        @(negedge clk);
        issue(8'd7, 8'd11, 1'b0, 2'b00, 1'b1, 16'd77, -1, -1, s);
        wait_until(s + 12);
        check("eval_iter5_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_y_valid", int'(y_valid), 0);
        check("abort_shift", int'(shift_HQ_LQ), 0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        issue(8'd7, 8'd11, 1'b0, 2'b00, 1'b1, 16'd77, -1, -1, s);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
